// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_FREE    = 2'b00;
  localparam logic [1:0] MODE_BOUNDED = 2'b01;
  localparam logic [1:0] MODE_STEP    = 2'b10;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the board-side driver and the run controller.
interface cpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       mode;
  logic             start;
  logic             step;
  logic             halt_in;
  logic [CNT_W-1:0] limit;
  logic             cpu_reset;
  logic             cpu_en;
  logic             done;
  logic             halted;
  logic [CNT_W-1:0] cycles;
  logic [2:0]       state;

  modport master (
    output mode, start, step, halt_in, limit,
    input  cpu_reset, cpu_en, done, halted, cycles, state
  );

  modport slave (
    input  mode, start, step, halt_in, limit,
    output cpu_reset, cpu_en, done, halted, cycles, state
  );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: CPU reset sequencing, then free/bounded/single-step clock-enable gating.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt;
  logic             halted_q, halted_d;
  logic             cnt_clr, cnt_inc, at_max;
  logic [CNT_W-1:0] cycles, post_cnt;
  logic             mode_step, mode_bounded;

  assign mode_step    = (bus.mode == MODE_STEP);
  assign mode_bounded = (bus.mode == MODE_BOUNDED);
  // Count as it will read after this cycle's increment, saturation included.
  assign post_cnt     = at_max ? cycles : cycles + CNT_W'(1);
  assign cnt_inc      = (state_q == ST_RUN) || (state_q == ST_STEP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RESET;
      rst_cnt  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      rst_cnt  <= (state_q == ST_RESET) ? rst_cnt + RC_W'(1) : '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (mode_step) begin
          if (bus.step) state_d = ST_STEP;
        end else if (bus.start) begin
          cnt_clr  = 1'b1;
          halted_d = 1'b0;
          state_d  = (mode_bounded && bus.limit == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.halt_in) begin
          state_d  = ST_DONE;
          halted_d = 1'b1;
        end else if (mode_bounded && post_cnt == bus.limit) begin
          state_d = ST_DONE;
        end
      end
      ST_STEP: begin
        if (bus.halt_in) begin
          state_d  = ST_DONE;
          halted_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_RESET;
          cnt_clr  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (cycles),
    .at_max (at_max)
  );

  assign bus.cpu_reset = (state_q == ST_RESET);
  assign bus.cpu_en    = cnt_inc;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.halted    = halted_q;
  assign bus.cycles    = cycles;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed + randomized bench for cpu_run_ctrl; expectations come from run-level rules.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic reset_na = 1'b0;
  logic reset_nb = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(16)) ifa ();
  cpu_run_ctrl_if #(.CNT_W(3))  ifb ();

  cpu_run_ctrl #(.RST_CYCLES(2), .CNT_W(16)) dut_a (
    .clk     (clk),
    .reset_n (reset_na),
    .bus     (ifa.slave)
  );

  cpu_run_ctrl #(.RST_CYCLES(2), .CNT_W(3)) dut_b (
    .clk     (clk),
    .reset_n (reset_nb),
    .bus     (ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with cpu_reset high starting from the current cycle, then checks IDLE.
  task automatic a_count_reset(input string tag);
    int unsigned n = 0;
    while (ifa.cpu_reset === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    check({tag, "_rst_len"}, n, 2);
    check({tag, "_state"}, ifa.state, 1);
    check({tag, "_en"}, ifa.cpu_en, 0);
    check({tag, "_cycles"}, ifa.cycles, 0);
    check({tag, "_halted"}, ifa.halted, 0);
  endtask

  task automatic a_rearm(input string tag);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check({tag, "_rearm_state"}, ifa.state, 0);
    check({tag, "_rearm_cycles"}, ifa.cycles, 0);
    a_count_reset(tag);
  endtask

  // One run from IDLE. halt_at = index of the enabled cycle during which halt_in is raised (0 = never).
  task automatic a_run(input logic [1:0] md, input int unsigned lim,
                       input int unsigned halt_at, input string tag);
    int unsigned exp_n, en, guard;
    logic exp_h;
    if (md == 2'b01) begin
      exp_h = (halt_at != 0) && (halt_at <= lim);
      exp_n = exp_h ? halt_at : lim;
    end else begin
      exp_h = 1'b1;
      exp_n = halt_at;
    end
    ifa.mode  = md;
    ifa.limit = 16'(lim);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check({tag, "_latency"}, ifa.cpu_en, (exp_n > 0) ? 1 : 0);
    en = 0;
    guard = 0;
    while (ifa.cpu_en === 1'b1 && guard < 200) begin
      en++;
      if (halt_at != 0 && en == halt_at) ifa.halt_in = 1'b1;
      tick();
      guard++;
    end
    ifa.halt_in = 1'b0;
    check({tag, "_en_count"}, en, exp_n);
    check({tag, "_done"}, ifa.done, 1);
    check({tag, "_cycles"}, ifa.cycles, exp_n);
    check({tag, "_halted"}, ifa.halted, exp_h);
    check({tag, "_state"}, ifa.state, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned en_total, guard, lim, hat, sel;
    logic [1:0] md;
    ifa.mode = 2'b00; ifa.start = 1'b0; ifa.step = 1'b0; ifa.halt_in = 1'b0; ifa.limit = '0;
    ifb.mode = 2'b00; ifb.start = 1'b0; ifb.step = 1'b0; ifb.halt_in = 1'b0; ifb.limit = '0;

    // Reset state while reset_n is held low.
    tick();
    tick();
    check("por_cpu_reset", ifa.cpu_reset, 1);
    check("por_en", ifa.cpu_en, 0);
    check("por_done", ifa.done, 0);
    check("por_cycles", ifa.cycles, 0);
    check("por_halted", ifa.halted, 0);
    check("por_state", ifa.state, 0);
    reset_na = 1'b1;
    reset_nb = 1'b1;
    a_count_reset("por");

    // Bounded run of 5, then re-arm through CPU reset.
    a_run(2'b01, 5, 0, "bnd5");
    a_rearm("bnd5");

    // Free run, halt raised after 7 enabled cycles; then halt coinciding with limit 8.
    a_run(2'b00, 0, 8, "free_halt");
    a_rearm("free_halt");
    a_run(2'b01, 8, 8, "coincide");
    a_rearm("coincide");
    a_run(2'b01, 0, 0, "lim0");
    a_rearm("lim0");

    // Single step: three pulses 4 cycles apart, start alongside the second.
    ifa.mode = 2'b10;
    en_total = 0;
    for (int i = 0; i < 3; i++) begin
      ifa.step  = 1'b1;
      ifa.start = (i == 1);
      for (int t = 0; t < 4; t++) begin
        tick();
        ifa.step  = 1'b0;
        ifa.start = 1'b0;
        if (ifa.cpu_en === 1'b1) en_total++;
        if (t == 0) check("step_state", ifa.state, 3);
      end
    end
    check("step_en_total", en_total, 3);
    check("step_cycles", ifa.cycles, 3);
    check("step_idle", ifa.state, 1);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check("step_mode_start_ignored", ifa.state, 1);
    ifa.mode = 2'b00;
    ifa.step = 1'b1;
    tick();
    ifa.step = 1'b0;
    check("free_mode_step_ignored", ifa.state, 1);
    check("free_mode_step_cycles", ifa.cycles, 3);
    // Halt observed during a step ends the run.
    ifa.mode = 2'b10;
    ifa.step = 1'b1;
    tick();
    ifa.step = 1'b0;
    ifa.halt_in = 1'b1;
    tick();
    ifa.halt_in = 1'b0;
    check("step_halt_done", ifa.done, 1);
    check("step_halt_halted", ifa.halted, 1);
    check("step_halt_cycles", ifa.cycles, 4);
    ifa.step = 1'b1;
    tick();
    ifa.step = 1'b0;
    check("done_step_ignored", ifa.state, 4);
    a_rearm("step");

    // Randomized runs against the run-level rules.
    for (int r = 0; r < 10; r++) begin
      sel = $urandom_range(0, 2);
      md  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b11 : 2'b01;
      lim = $urandom_range(0, 30);
      if (md == 2'b01) hat = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 35);
      else             hat = $urandom_range(1, 30);
      a_run(md, lim, hat, $sformatf("rnd%0d", r));
      a_rearm($sformatf("rnd%0d", r));
    end

    // Asynchronous reset mid-run at cycles=4.
    ifa.mode = 2'b00;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    guard = 0;
    while (ifa.cycles !== 16'd4 && guard < 20) begin
      tick();
      guard++;
    end
    check("mid_pre_cycles", ifa.cycles, 4);
    #2 reset_na = 1'b0;
    #1;
    check("mid_en", ifa.cpu_en, 0);
    check("mid_cpu_reset", ifa.cpu_reset, 1);
    check("mid_cycles", ifa.cycles, 0);
    check("mid_state", ifa.state, 0);
    check("mid_done", ifa.done, 0);
    tick();
    reset_na = 1'b1;
    a_count_reset("mid");

    // Narrow counter: saturation at 7, then limit 0 and limit 7.
    ifb.mode = 2'b00;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    repeat (12) tick();
    check("sat_cycles", ifb.cycles, 7);
    check("sat_en", ifb.cpu_en, 1);
    ifb.halt_in = 1'b1;
    tick();
    ifb.halt_in = 1'b0;
    check("sat_done", ifb.done, 1);
    check("sat_hold", ifb.cycles, 7);
    check("sat_halted", ifb.halted, 1);
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    guard = 0;
    while (ifb.cpu_reset === 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("b_rearm_len", guard, 2);
    ifb.mode = 2'b01;
    ifb.limit = 3'd0;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    check("b_lim0_en", ifb.cpu_en, 0);
    check("b_lim0_done", ifb.done, 1);
    check("b_lim0_cycles", ifb.cycles, 0);
    check("b_lim0_halted", ifb.halted, 0);
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    guard = 0;
    while (ifb.cpu_reset === 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    ifb.limit = 3'd7;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    en_total = 0;
    while (ifb.cpu_en === 1'b1 && en_total < 40) begin
      en_total++;
      tick();
    end
    check("b_lim7_en", en_total, 7);
    check("b_lim7_done", ifb.done, 1);
    check("b_lim7_cycles", ifb.cycles, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller sitting between the board keys/switches and the CPU top. It sequences a CPU reset pulse of configurable length, then gates CPU progress with a clock-enable in one of three modes: free run, bounded run of N cycles, or single step. It counts enabled cycles and reports completion on CPU halt or cycle limit. This replaces hand-driven clock/reset sequencing with a synthesizable, repeatable controller.

## Interface
- `RST_CYCLES`, default 2: number of cycles `cpu_reset` is held after entering RESET; must be ≥1.
- `CNT_W`, default 16: width of the cycle counter and of `limit`.

- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mode` in 2: 00 free run, 01 bounded run, 10 single step, 11 treated as 00.
- `start` in 1: single-cycle pulse; begins a run (IDLE) or re-arms (DONE).
- `step` in 1: single-cycle pulse; one enabled cycle in step mode.
- `halt_in` in 1: CPU halted indication, registered in the CPU.
- `limit` in CNT_W: enabled-cycle budget for bounded run; sampled every cycle in RUN.
- `cpu_reset` out 1: active-high reset to the CPU.
- `cpu_en` out 1: CPU clock enable.
- `done` out 1: run finished.
- `halted` out 1: last run ended because of `halt_in`.
- `cycles` out CNT_W: enabled cycles since the count was last cleared, saturating.
- `state` out 3: encoded FSM state for LED display.

## Operation
- States: RESET=0, IDLE=1, RUN=2, STEP=3, DONE=4.
- While `reset_n`=0: state RESET, reset counter 0, `cycles`=0, `halted`=0. Outputs: `cpu_reset`=1, `cpu_en`=0, `done`=0.
- RESET:
  - `cpu_reset`=1 for exactly RST_CYCLES cycles, then go to IDLE.
  - Entry clears `cycles` and `halted`.
- IDLE:
  - `start` with mode≠10 goes to RUN and clears `cycles`.
  - If mode=01 and `limit`=0, `start` goes directly to DONE with zero enabled cycles and `halted`=0.
  - `step` with mode=10 goes to STEP; a simultaneous `start` is ignored.
  - `step` with mode≠10 is ignored.
  - `start` with mode=10 is ignored.
- STEP: `cpu_en`=1 for one cycle, `cycles` increments, then return to IDLE. `halt_in`=1 in STEP goes to DONE with `halted`=1.
- RUN:
  - `cpu_en`=1 each cycle, and `cycles` increments each cycle.
  - `halt_in`=1 goes to DONE with `halted`=1.
  - In bounded mode, when the post-increment count equals `limit`, go to DONE.
  - If halt and limit coincide, go to DONE with `halted`=1.
- DONE: `done`=1, `cpu_en`=0, and `cycles` is held. `start` goes to RESET, re-running from CPU reset. `step` is ignored.
- `cycles` saturates at 2^CNT_W−1 and never wraps.
- `mode` and `limit` changes mid-run take effect on the next cycle.

## Timing
- `cpu_reset`, `cpu_en`, `done`, and `state` are Moore outputs decoded from registered state. No combinational input→output paths.
- Start latency: the `start` pulse at edge k gives first `cpu_en`=1 in cycle k+1.
- A bounded run with `limit`=N yields exactly N cycles with `cpu_en`=1, then `done`=1 in the following cycle.
- A `halt_in` sampled high at edge k: `cpu_en`=0 from cycle k+1. The enabled cycle k is counted.
- Asynchronous reset mid-run forces reset values immediately. Deassertion is synchronous to the next `clk` edge.

## Structure
- Package `cpu_run_ctrl_pkg` holds:
  - the state enum typedef with the fixed encodings above;
  - mode constants MODE_FREE, MODE_BOUNDED, MODE_STEP.
- One sub-module, `sat_counter`, parametrised by width, with clear, increment, and saturation. It is used for `cycles`. The reset counter is inline.

## Test plan
- Reset release with RST_CYCLES=2 → `cpu_reset`=1 for 2 cycles, then state=1, `cpu_en`=0, `cycles`=0.
- mode=01, `limit`=5, `start` → exactly 5 `cpu_en` cycles, `cycles`=5, `done`=1, `halted`=0. A second `start` → RESET, then IDLE.
- mode=00, `start`, `halt_in` raised after 7 enabled cycles → `cycles`=8, `done`=1, `halted`=1. Also `halt_in` coinciding with `limit`=8 in mode 01 → same result.
- mode=10, three `step` pulses spaced 4 cycles apart, `start` simultaneous with the 2nd → exactly 3 single `cpu_en` cycles, `cycles`=3, state returns to 1.
- CNT_W=3, mode=00, no halt for 12 cycles → `cycles` holds 7. mode=01 with `limit`=0 → `done` with `cycles`=0.
- `reset_n` pulsed low mid-RUN at `cycles`=4 → immediately `cpu_en`=0, `cpu_reset`=1, `cycles`=0, state=0.
